// File: rtl/baccarat_fsm.sv
// Baccarat deal controller.
// Sequences the card-register loads for the player and dealer hands, applies
// the natural-win and third-card rules using the live scores returned by the
// datapath, and drives the win lights when the hand completes.
// Optional build macro STEP_GATE_EN: when defined, the state register advances
// only on edges where step = 1, so the block can run on a fast clock with a
// debounced step pulse. When undefined, step has no effect.
module baccarat_fsm (
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pcard3,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    typedef enum logic [3:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        EVAL    = 4'd4,
        DEAL_P3 = 4'd5,
        BANKER  = 4'd6,
        DEAL_D3 = 4'd7,
        DONE    = 4'd8
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic       advance;
    logic [3:0] p3_val;
    logic       banker_draw;

`ifdef STEP_GATE_EN
    assign advance = step;
`else
    // step has no effect in the ungated build; the state moves on every edge.
    assign advance = step | 1'b1;
`endif

    // Baccarat value of the player's third card: tens and face cards count 0.
    always_comb begin
        p3_val = (pcard3 >= 4'd10) ? 4'd0 : pcard3;
    end

    // Banker third-card table indexed by the dealer score and the player's third card.
    always_comb begin
        banker_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
            4'd3:             banker_draw = (p3_val != 4'd8);
            4'd4:             banker_draw = (p3_val >= 4'd2) && (p3_val <= 4'd7);
            4'd5:             banker_draw = (p3_val >= 4'd4) && (p3_val <= 4'd7);
            4'd6:             banker_draw = (p3_val == 4'd6) || (p3_val == 4'd7);
            default:          banker_draw = 1'b0;
        endcase
    end

    // Next-state logic: fixed deal order, then the natural and third-card rules.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        state_d = DEAL_P1;
        case (state_q)
            DEAL_P1: state_d = DEAL_D1;
            DEAL_D1: state_d = DEAL_P2;
            DEAL_P2: state_d = DEAL_D2;
            DEAL_D2: state_d = EVAL;
            EVAL: begin
                // Scores above 9 also satisfy >= 8 and so end the hand as a natural.
                if (pscore >= 4'd8 || dscore >= 4'd8) begin
                    state_d = DONE;
                end else if (pscore <= 4'd5) begin
                    state_d = DEAL_P3;
                end else if (dscore <= 4'd5) begin
                    state_d = DEAL_D3;
                end else begin
                    state_d = DONE;
                end
            end
            DEAL_P3: state_d = BANKER;
            BANKER:  state_d = banker_draw ? DEAL_D3 : DONE;
            DEAL_D3: state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = DEAL_P1;
        endcase
    end

    // State register: synchronous reset to DEAL_P1, optionally gated by step.
    always_ff @(posedge slow_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= DEAL_P1;
        end else if (advance) begin
            state_q <= state_d;
        end
    end

    // Output decode: one load strobe per deal state, lights only in DONE, all low during reset.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        hand_done        = 1'b0;
        if (!reset) begin
            case (state_q)
                DEAL_P1: load_pcard1 = 1'b1;
                DEAL_D1: load_dcard1 = 1'b1;
                DEAL_P2: load_pcard2 = 1'b1;
                DEAL_D2: load_dcard2 = 1'b1;
                DEAL_P3: load_pcard3 = 1'b1;
                DEAL_D3: load_dcard3 = 1'b1;
                DONE: begin
                    hand_done        = 1'b1;
                    player_win_light = (pscore >= dscore);
                    dealer_win_light = (dscore >= pscore);
                end
                default: ;
            endcase
        end
    end

endmodule
